// File: rtl/ad7476a_sample_ctrl.sv
// AD7476A conversion scheduler: periodic ss/sck frame, 16-bit capture, header check.
// Latency: ss low 1 cycle after tick, sample 33*CLK_DIV later; backpressure: one-deep holding register, overwrite counts overrun.
module ad7476a_sample_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2272,
    parameter int QUIET_CYCLES  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        miso,
    output logic        ss,
    output logic        sck,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  overrun_cnt
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int HW = $clog2(CLK_DIV);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           pending_q, pending_d;
    logic [HW-1:0]  hc_q, hc_d;
    logic [5:0]     edge_q, edge_d;
    logic [QW-1:0]  qc_q, qc_d;
    logic [15:0]    shreg_q, shreg_d;
    logic           ss_q, ss_d;
    logic           sck_q, sck_d;
    logic [11:0]    data_q, data_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [7:0]     ovr_q, ovr_d;

    logic tick, frame_done, load, accept;

    always_comb begin
        tick       = enable && (timer_q == '0);
        timer_d    = '0;
        if (enable) begin
            timer_d = (timer_q == TW'(SAMPLE_PERIOD - 1)) ? '0 : timer_q + TW'(1);
        end
        pending_d  = pending_q | tick;
        state_d    = state_q;
        hc_d       = hc_q;
        edge_d     = edge_q;
        qc_d       = qc_q;
        shreg_d    = shreg_q;
        ss_d       = ss_q;
        sck_d      = sck_q;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                // Taking the tick directly keeps ss one cycle behind it.
                if (pending_q || tick) begin
                    state_d   = SHIFT;
                    ss_d      = 1'b0;
                    sck_d     = 1'b1;
                    hc_d      = '0;
                    edge_d    = '0;
                    pending_d = 1'b0;
                end
            end
            SHIFT: begin
                if (hc_q == HW'(CLK_DIV - 1)) begin
                    hc_d = '0;
                    if (edge_q == 6'd32) begin
                        state_d    = QUIET;
                        ss_d       = 1'b1;
                        qc_d       = '0;
                        frame_done = 1'b1;
                    end else begin
                        sck_d  = ~sck_q;
                        edge_d = edge_q + 6'd1;
                        if (!sck_q) begin
                            shreg_d = {shreg_q[14:0], miso};
                        end
                    end
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end
            QUIET: begin
                if (qc_q == QW'(QUIET_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    qc_d = qc_q + QW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ss_d    = 1'b1;
                sck_d   = 1'b1;
            end
        endcase

        err_d   = frame_done && (shreg_q[15:12] != 4'h0);
        load    = frame_done && (shreg_q[15:12] == 4'h0);
        accept  = valid_q && sample_ready;
        data_d  = load ? shreg_q[11:0] : data_q;
        valid_d = load ? 1'b1 : (accept ? 1'b0 : valid_q);
        ovr_d   = ovr_q;
        if (load && valid_q && !sample_ready && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            hc_q      <= '0;
            edge_q    <= '0;
            qc_q      <= '0;
            shreg_q   <= '0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            hc_q      <= hc_d;
            edge_q    <= edge_d;
            qc_q      <= qc_d;
            shreg_q   <= shreg_d;
            ss_q      <= ss_d;
            sck_q     <= sck_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ss           = ss_q;
    assign sck          = sck_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign frame_err    = err_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_ad7476a_sample_ctrl.sv
// Directed bench for ad7476a_sample_ctrl: ADC serial model, sample scoreboard, timing monitor.
module tb_ad7476a_sample_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        miso;
    logic        ss;
    logic        sck;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        frame_err;
    logic [7:0]  overrun_cnt;

    ad7476a_sample_ctrl #(
        .CLK_DIV(4),
        .SAMPLE_PERIOD(2272),
        .QUIET_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .miso(miso),
        .ss(ss),
        .sck(sck),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy(busy),
        .frame_err(frame_err),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] adc_q[$];
    logic [11:0] exp_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx  = 15;

    // ADC model: latch next word at ss fall, present one bit per sck fall.
    always @(negedge ss or negedge sck) begin
        if (sck) begin
            cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
            bit_idx  = 15;
        end else if (!ss) begin
            miso    = cur_word[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    int cyc      = 0;
    int err_cnt  = 0;
    int ss_fall_q[$];
    int rise_q[$];
    logic prev_ss  = 1'b1;
    logic prev_sck = 1'b1;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (prev_ss && !ss) ss_fall_q.push_back(cyc);
        if (!prev_sck && sck) rise_q.push_back(cyc);
        if (frame_err) err_cnt++;
        prev_ss  = ss;
        prev_sck = sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk); #2;
            ok = sample_valid;
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk); #2;
            ok = !busy;
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_err(input string tag, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk); #2;
            ok = frame_err;
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic run_frame();
        enable = 1'b1;
        @(posedge clk); #2;
        enable = 1'b0;
    endtask

    int t_v, base, nf, e0;
    logic [11:0] w;

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        miso         = 1'b0;
        sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ss", 32'(ss), 1);
        check("rst_sck", 32'(sck), 1);
        check("rst_data", 32'(sample_data), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun_cnt), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // Basic capture
        adc_q.push_back(16'h0ABC);
        exp_q.push_back(12'hABC);
        rise_q.delete();
        enable = 1'b1;
        @(posedge clk); #2;
        check("basic_ss_low", 32'(ss), 0);
        check("basic_busy", 32'(busy), 1);
        wait_valid("basic_valid_timeout", 200);
        enable = 1'b0;
        t_v = cyc;
        check("basic_latency", 32'(t_v - ss_fall_q[$]), 132);
        check("basic_data", 32'(sample_data), 32'(exp_q.pop_front()));
        check("basic_ss_high", 32'(ss), 1);
        check("basic_rises", 32'(rise_q.size()), 16);
        check("basic_first_rise", 32'(rise_q[0] - ss_fall_q[$]), 8);
        check("basic_rise_span", 32'(rise_q[15] - rise_q[0]), 120);
        @(posedge clk); #2;
        check("basic_valid_1cyc", 32'(sample_valid), 0);
        wait_idle("basic_idle", 20);

        // Rate: three periodic conversions
        base = ss_fall_q.size();
        for (int k = 1; k <= 3; k++) begin
            adc_q.push_back(16'(k));
            exp_q.push_back(12'(k));
        end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("rate_valid_timeout", 2500);
            check("rate_data", 32'(sample_data), 32'(exp_q.pop_front()));
        end
        enable = 1'b0;
        check("rate_frames", 32'(ss_fall_q.size() - base), 3);
        check("rate_period_1", 32'(ss_fall_q[base+1] - ss_fall_q[base]), 2272);
        check("rate_period_2", 32'(ss_fall_q[base+2] - ss_fall_q[base+1]), 2272);
        check("rate_no_err", 32'(err_cnt), 0);
        wait_idle("rate_idle", 50);

        // Frame error
        e0 = err_cnt;
        adc_q.push_back(16'h8123);
        run_frame();
        wait_err("ferr_timeout", 200);
        check("ferr_valid", 32'(sample_valid), 0);
        check("ferr_data", 32'(sample_data), 'h003);
        @(posedge clk); #2;
        check("ferr_pulse", 32'(frame_err), 0);
        wait_idle("ferr_idle", 20);
        check("ferr_count", 32'(err_cnt - e0), 1);
        check("ferr_valid_after", 32'(sample_valid), 0);

        // Simultaneous accept and load
        sample_ready = 1'b0;
        adc_q.push_back(16'h05A5);
        run_frame();
        wait_valid("sim_first_timeout", 200);
        wait_idle("sim_first_idle", 20);
        check("sim_first_data", 32'(sample_data), 'h5A5);
        adc_q.push_back(16'h0C3C);
        enable = 1'b1;
        @(posedge clk); #2;
        enable = 1'b0;
        repeat (131) @(posedge clk);
        #2;
        sample_ready = 1'b1;
        @(posedge clk); #2;
        sample_ready = 1'b0;
        check("sim_valid", 32'(sample_valid), 1);
        check("sim_data", 32'(sample_data), 'hC3C);
        check("sim_ovr", 32'(overrun_cnt), 0);
        wait_idle("sim_idle", 20);
        sample_ready = 1'b1;
        @(posedge clk); #2;
        sample_ready = 1'b0;
        check("sim_drain", 32'(sample_valid), 0);

        // Overrun with consumer stalled for 300 frames
        for (int i = 1; i <= 300; i++) begin
            w = 12'(12'h400 + i);
            adc_q.push_back({4'h0, w});
            run_frame();
            wait_idle("ovr_idle", 200);
            if (i == 1)   check("ovr_first", 32'(overrun_cnt), 0);
            if (i == 10)  check("ovr_10", 32'(overrun_cnt), 9);
            if (i == 256) check("ovr_256", 32'(overrun_cnt), 255);
            if (i == 257) check("ovr_sat", 32'(overrun_cnt), 255);
        end
        check("ovr_data", 32'(sample_data), 'h400 + 300);
        check("ovr_valid", 32'(sample_valid), 1);
        check("ovr_final", 32'(overrun_cnt), 255);
        sample_ready = 1'b1;
        @(posedge clk); #2;
        check("ovr_ready_clear", 32'(sample_valid), 0);

        // Enable dropped during bit 7
        adc_q.push_back(16'h0777);
        exp_q.push_back(12'h777);
        nf = ss_fall_q.size();
        enable = 1'b1;
        @(posedge clk); #2;
        repeat (51) @(posedge clk);
        #2;
        enable = 1'b0;
        check("en_mid_busy", 32'(busy), 1);
        wait_valid("en_mid_valid_timeout", 200);
        check("en_mid_data", 32'(sample_data), 32'(exp_q.pop_front()));
        repeat (2400) @(posedge clk);
        #2;
        check("en_mid_no_more_ss", 32'(ss_fall_q.size() - nf), 1);
        check("en_mid_ss_idle", 32'(ss), 1);
        check("en_mid_busy_idle", 32'(busy), 0);

        // Reset asserted during bit 7
        adc_q.push_back(16'h0999);
        nf = ss_fall_q.size();
        e0 = err_cnt;
        enable = 1'b1;
        @(posedge clk); #2;
        repeat (51) @(posedge clk);
        #2;
        check("rst_mid_ss_before", 32'(ss), 0);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_mid_ss", 32'(ss), 1);
        check("rst_mid_sck", 32'(sck), 1);
        check("rst_mid_valid", 32'(sample_valid), 0);
        check("rst_mid_data", 32'(sample_data), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #2;
        check("rst_mid_no_sample", 32'(sample_valid), 0);
        check("rst_mid_no_err", 32'(err_cnt - e0), 0);
        check("rst_mid_no_ss", 32'(ss_fall_q.size() - nf), 1);
        check("rst_mid_ovr", 32'(overrun_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ad7476a_sample_ctrl.md
# ad7476a_sample_ctrl

Conversion scheduler and serial capture engine for the AD7476A 12-bit ADC. The block starts conversions at a fixed, programmable sample rate. It drives the ADC's `ss`/`sck` lines, shifts in the 16-bit frame, and checks the four leading zeros. Each 12-bit sample is delivered to downstream logic (LED display, PWM audio path) through a valid/ready holding register with overrun accounting.

## Interface
- `CLK_DIV`, 4: `sck` half-period in `clk` cycles; must be ≥ 2 (4 → 12.5 MHz `sck` at 100 MHz `clk`).
- `SAMPLE_PERIOD`, 2272: `clk` cycles between conversion starts; must be ≥ 33·`CLK_DIV` + `QUIET_CYCLES` + 2.
- `QUIET_CYCLES`, 5: minimum `ss`-high time after a frame, in `clk` cycles.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: high = periodic conversions run.
- `miso` in 1: ADC serial data, MSB first, changes after `sck` falling edge.
- `ss` out 1: ADC chip select, active low.
- `sck` out 1: ADC serial clock, idles high.
- `sample_data` out 12: last accepted conversion result.
- `sample_valid` out 1: `sample_data` holds an unconsumed sample.
- `sample_ready` in 1: consumer accepts when `sample_valid` && `sample_ready`.
- `busy` out 1: frame in progress (`ss` low or quiet period).
- `frame_err` out 1: one-cycle pulse when a frame's bits 15:12 are not all zero.
- `overrun_cnt` out 8: count of samples overwritten before being consumed; saturates at 255.

## Operation
- Reset values: `ss`=1, `sck`=1, `sample_data`=0, `sample_valid`=0, `busy`=0, `frame_err`=0, `overrun_cnt`=0, state IDLE, rate timer 0, pending=0. Reset mid-frame aborts the frame immediately; no sample or error is produced.
- **Rate timer**
  - Counts 0..`SAMPLE_PERIOD`-1 while `enable`=1 and wraps.
  - It is held at 0 while `enable`=0, so the first tick occurs in the cycle `enable` is first seen high.
  - A tick occurs when `enable`=1 and the timer = 0.
  - A tick sets `pending`. `pending` clears when a frame starts. A tick while `pending`=1 is lost silently; this is only possible if `SAMPLE_PERIOD` is violated.
- **FSM states: IDLE, SHIFT, QUIET.**
  - IDLE → SHIFT when `pending`=1. The block drives `ss`=0, clears the bit counter, and starts the half-period counter.
  - SHIFT: `sck` toggles every `CLK_DIV` cycles, starting with a falling edge `CLK_DIV` cycles after `ss` falls. On each clock edge where `sck` is driven 0→1, `miso` is shifted into a 16-bit register, MSB first. After the 16th rising edge, the FSM waits one more half-period, then moves SHIFT → QUIET with `ss`=1.
  - QUIET: `ss`=1, `sck`=1 for `QUIET_CYCLES` cycles, then → IDLE.
  - `enable` falling mid-frame does not abort the frame. The frame completes normally and no further ticks occur.
- **Frame check**
  - Frame = {4 zeros, D11..D0}.
  - Bits 15:12 ≠ 0: `frame_err` pulses and the sample is discarded (`sample_data`/`sample_valid` unchanged).
  - Otherwise the block loads bits 11:0 into `sample_data` and sets `sample_valid`.
- **Handshake / overrun**
  - `sample_valid` stays 1 until `sample_ready`=1 is seen; it clears the following edge.
  - A new sample loaded while `sample_valid`=1 and `sample_ready`=0 overwrites the old sample, keeps `valid`=1, and increments `overrun_cnt` (saturating at 255).
  - New sample loaded in the same cycle as an accept: the new data is loaded, `valid` stays 1, and there is no overrun.
- `busy` = (state ≠ IDLE).

## Timing
- Tick at cycle t0. Then:
  - `ss`=0 at t0+1.
  - First `sck` fall at t0+1+`CLK_DIV`.
  - k-th `sck` rise (k=1..16) at t0+1+2k·`CLK_DIV`.
  - `ss`=1, `sample_valid`/`frame_err` at t0+1+33·`CLK_DIV`.
  - IDLE at t0+1+33·`CLK_DIV`+`QUIET_CYCLES`.
- With defaults: 132 cycles from `ss` low to `sample_valid`. The frame plus quiet period takes 138 cycles, within the 2272-cycle period (44.01 kHz).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic capture.** Setup: ADC model drives 0x0ABC on `sck` falling edges while `ss` low, `sample_ready`=1, `enable` raised. Required:
  - `ss` falls 1 cycle after the tick.
  - 16 `sck` pulses of 8 cycles each.
  - `sample_data`=0xABC with `valid` for 1 cycle, 132 cycles after `ss` falls.
- **Rate.** Setup: `enable` held for 3 periods, model increments data each frame. Required: `ss` falling edges exactly 2272 cycles apart; samples 0x001, 0x002, 0x003 in order; `frame_err` never asserted.
- **Frame error.** Stimulus: model sends 0x8123. Required: `frame_err` pulses once, `sample_valid` stays 0, `sample_data` unchanged.
- **Overrun.** Setup: `sample_ready`=0 for 300 consecutive frames. Required:
  - `sample_data` = most recent value.
  - `overrun_cnt` saturates at 255.
  - Raising `ready` clears `valid` on the next edge.
- **Simultaneous accept/load.** Stimulus: `sample_ready` pulsed in the exact completion cycle of a frame. Required: new value loaded, `valid`=1, `overrun_cnt` unchanged.
- **Reset / enable mid-frame.**
  - `rst_n` low during bit 7: `ss`/`sck` go to 1 immediately, no sample.
  - `enable` dropped during bit 7: frame completes with a valid sample, and no further `ss` activity follows.
